// File: rtl/bpu_btb_pkg.sv
// Shared types for the branch target buffer: entry layout, counter encodings, walk FSM states.
// Entry ctr field exists only when BPU_BHT_EN is defined.
package bpu_btb_pkg;

  // Tag storage is sized for the smallest legal table (4 entries) and zero-extended for larger ones.
  localparam int BTB_TAG_W_MAX = 28;

  localparam logic [1:0] BTB_CTR_SNT = 2'b00;
  localparam logic [1:0] BTB_CTR_WNT = 2'b01;
  localparam logic [1:0] BTB_CTR_WT  = 2'b10;
  localparam logic [1:0] BTB_CTR_ST  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } btb_state_t;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_W_MAX-1:0] tag;
    logic [29:0]              target;
    logic                     is_jump;
`ifdef BPU_BHT_EN
    logic [1:0]               ctr;
`endif
  } btb_entry_t;

  function automatic logic [BTB_TAG_W_MAX-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return BTB_TAG_W_MAX'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/bpu_btb_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
// Present only when BPU_BHT_EN is defined.
`ifdef BPU_BHT_EN
module btb_sat_ctr
  import bpu_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != BTB_CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != BTB_CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule
`endif

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with optional bimodal counters (BPU_BHT_EN); same-cycle lookup, edge-committed training.
// state | meaning:  IDLE | lookups and training active;  CLEAR | invalidation walk, one entry per cycle
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jump,
  input  logic        flush_i,
  output logic        busy
);

  btb_entry_t table_q [ENTRIES];

  btb_state_t state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_en;

  logic [IDX_W-1:0]         lk_idx, upd_idx;
  logic [BTB_TAG_W_MAX-1:0] lk_tag, upd_tag;
  logic                     lk_hit, lk_taken, upd_hit, upd_ok;
  logic                     unused_bits;

  assign busy        = (state_q == CLEAR);
  assign unused_bits = ^upd_target[1:0];

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = btb_tag(if_pc, IDX_W);
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = btb_tag(upd_pc, IDX_W);

  assign lk_hit  = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
  assign upd_hit = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);
  assign upd_ok  = upd_valid && !busy && !flush_i;

`ifdef BPU_BHT_EN
  logic [1:0] ctr_nxt;

  btb_sat_ctr u_sat_ctr (
    .ctr     (table_q[upd_idx].ctr),
    .taken   (upd_taken),
    .ctr_nxt (ctr_nxt)
  );

  assign lk_taken = table_q[lk_idx].is_jump || table_q[lk_idx].ctr[1];
`else
  assign lk_taken = 1'b1;
`endif

  always_comb begin
    pred_valid = if_valid && !busy && lk_hit && lk_taken;
    pred_pc    = if_pc + 32'd4;
    if (pred_valid) pred_pc = {table_q[lk_idx].target, 2'b00};
  end

  // Walk FSM: a flush in either state (re)starts the walk at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (flush_i) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
`ifdef BPU_BHT_EN
        table_q[i].ctr <= BTB_CTR_WNT;
`endif
      end
    end else if (clr_en) begin
      table_q[clr_idx_q].valid <= 1'b0;
`ifdef BPU_BHT_EN
      table_q[clr_idx_q].ctr <= BTB_CTR_WNT;
`endif
    end else if (upd_ok) begin
      if (upd_hit) begin
`ifdef BPU_BHT_EN
        table_q[upd_idx].ctr <= ctr_nxt;
`endif
        if (upd_taken) begin
          table_q[upd_idx].target  <= upd_target[31:2];
          table_q[upd_idx].is_jump <= upd_is_jump;
        end
`ifndef BPU_BHT_EN
        // Without counters a not-taken conditional branch simply drops out of the table.
        else if (!table_q[upd_idx].is_jump) begin
          table_q[upd_idx].valid <= 1'b0;
        end
`endif
      end else if (upd_taken) begin
        table_q[upd_idx].valid   <= 1'b1;
        table_q[upd_idx].tag     <= upd_tag;
        table_q[upd_idx].target  <= upd_target[31:2];
        table_q[upd_idx].is_jump <= upd_is_jump;
`ifdef BPU_BHT_EN
        table_q[upd_idx].ctr <= BTB_CTR_WT;
`endif
      end
    end
  end

endmodule
